// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, condition/memory codes, flag indices and FSM states for alu_seq
// ALU_SEQ_MUL_EN adds the MUL state to the state enum.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOVN = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_ROR  = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_ADR  = 4'b1100;
  localparam logic [3:0] OP_LDR  = 4'b1101;
  localparam logic [3:0] OP_STR  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [1:0] CC_AL = 2'b00;
  localparam logic [1:0] CC_EQ = 2'b01;
  localparam logic [1:0] CC_NE = 2'b10;
  localparam logic [1:0] CC_LT = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_RESP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RESP} state_t;
`endif

  function automatic logic cond_pass(input logic [1:0] cc, input logic [3:0] f);
    logic ok;
    ok = 1'b1;
    case (cc)
      CC_EQ:   ok = f[FLAG_Z];
      CC_NE:   ok = ~f[FLAG_Z];
      CC_LT:   ok = f[FLAG_N] ^ f[FLAG_V];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one multiplier bit per cycle
// o_done is combinational in the final iteration so the caller can load the product on that edge.
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_hi_nz
);
  localparam int CNT_W = $clog2(WIDTH);

  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign o_lo      = w_acc_nxt[WIDTH-1:0];
  assign o_hi_nz   = |w_acc_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential conditional ALU with registered N/Z/C/V flags and handshaked result
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise opcode MUL acts as NOP.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 7
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [1:0]       Cond,
  input  logic [3:0]       Op_C,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [IMM_W-1:0] Ld_Sh,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out,
  output logic             Wr_En,
  output logic [1:0]       Mem_Op,
  output logic [3:0]       Flag
);
  localparam int SH_W = $clog2(WIDTH);

  state_t           r_state, w_state_nxt, w_start_state;
  logic [WIDTH-1:0] r_out;
  logic             r_wr;
  logic [1:0]       r_mem;
  logic [3:0]       r_flag;

  logic             w_accept, w_cond_ok, w_mul_go;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [3:0]       w_add_f, w_sub_f, w_fnew;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_imm, w_ror, w_res;
  logic             w_wr, w_fupd;
  logic [1:0]       w_mem;

  assign w_accept  = In_Valid & In_Ready;
  assign w_cond_ok = cond_pass(Cond, r_flag);
  assign w_sum     = {1'b0, Reg1} + {1'b0, Reg2};
  assign w_diff    = {1'b0, Reg1} - {1'b0, Reg2};
  assign w_sh      = Ld_Sh[SH_W-1:0];
  assign w_imm     = WIDTH'(Ld_Sh);
  assign w_ror     = WIDTH'({Reg1, Reg1} >> w_sh);

  // {N,Z,C,V}; for subtraction C means "no borrow"
  assign w_add_f = {w_sum[WIDTH-1], ~|w_sum[WIDTH-1:0], w_sum[WIDTH],
                    (Reg1[WIDTH-1] == Reg2[WIDTH-1]) && (w_sum[WIDTH-1] != Reg1[WIDTH-1])};
  assign w_sub_f = {w_diff[WIDTH-1], ~|w_diff[WIDTH-1:0], ~w_diff[WIDTH],
                    (Reg1[WIDTH-1] != Reg2[WIDTH-1]) && (w_diff[WIDTH-1] != Reg1[WIDTH-1])};

  always_comb begin
    w_res  = '0;
    w_wr   = 1'b0;
    w_mem  = MEM_NONE;
    w_fupd = 1'b0;
    w_fnew = r_flag;
    case (Op_C)
      OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_wr = 1'b1; w_fupd = 1'b1; w_fnew = w_add_f; end
      OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_wr = 1'b1; w_fupd = 1'b1; w_fnew = w_sub_f; end
      OP_CMP:  begin w_res = w_diff[WIDTH-1:0];              w_fupd = 1'b1; w_fnew = w_sub_f; end
      OP_OR:   begin w_res = Reg1 | Reg2;  w_wr = 1'b1; end
      OP_AND:  begin w_res = Reg1 & Reg2;  w_wr = 1'b1; end
      OP_XOR:  begin w_res = Reg1 ^ Reg2;  w_wr = 1'b1; end
      OP_MOVN: begin w_res = w_imm;        w_wr = 1'b1; end
      OP_MOV:  begin w_res = Reg2;         w_wr = 1'b1; end
      OP_SHR:  begin w_res = Reg1 >> w_sh; w_wr = 1'b1; end
      OP_SHL:  begin w_res = Reg1 << w_sh; w_wr = 1'b1; end
      OP_ROR:  begin w_res = w_ror;        w_wr = 1'b1; end
      OP_ADR:  begin w_res = Reg1 + w_imm; w_wr = 1'b1; end
      OP_LDR:  begin w_res = Reg1; w_mem = MEM_LOAD;  end
      OP_STR:  begin w_res = Reg1; w_mem = MEM_STORE; end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_lo;
  logic             w_mul_hi_nz;

  assign w_mul_go = w_accept && w_cond_ok && (Op_C == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_start (w_mul_go),
    .i_a     (Reg1),
    .i_b     (Reg2),
    .o_done  (w_mul_done),
    .o_lo    (w_mul_lo),
    .o_hi_nz (w_mul_hi_nz)
  );
`else
  assign w_mul_go = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_start_state = ST_RESP;
`ifdef ALU_SEQ_MUL_EN
    if (w_mul_go) w_start_state = ST_MUL;
`endif
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_start_state;
`ifdef ALU_SEQ_MUL_EN
      ST_MUL:  if (w_mul_done) w_state_nxt = ST_RESP;
`endif
      ST_RESP: if (Out_Ready) w_state_nxt = w_accept ? w_start_state : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    In_Ready  = (r_state == ST_IDLE) || ((r_state == ST_RESP) && Out_Ready);
    Out_Valid = (r_state == ST_RESP);
  end

  // A skipped instruction still answers, but with a zero result and no side effects
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out  <= '0;
      r_wr   <= 1'b0;
      r_mem  <= MEM_NONE;
      r_flag <= '0;
    end else if (w_accept && !w_mul_go) begin
      r_out <= w_cond_ok ? w_res : '0;
      r_wr  <= w_cond_ok && w_wr;
      r_mem <= w_cond_ok ? w_mem : MEM_NONE;
      if (w_cond_ok && w_fupd) r_flag <= w_fnew;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (w_mul_done) begin
      r_out  <= w_mul_lo;
      r_wr   <= 1'b1;
      r_mem  <= MEM_NONE;
      r_flag <= {w_mul_lo[WIDTH-1], ~|w_mul_lo, w_mul_hi_nz, w_mul_hi_nz};
    end
`endif
  end

  assign Out    = r_out;
  assign Wr_En  = r_wr;
  assign Mem_Op = r_mem;
  assign Flag   = r_flag;

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised successor to the processor's combinational ALU. Accepts one instruction (opcode, condition, two operands, immediate) per valid/ready handshake, evaluates the condition against internally registered N/Z/C/V flags, and returns a registered result with write-enable and memory-op qualifiers. MUL runs as an iterative shift-add over WIDTH cycles. All other ops complete in one cycle. The block sits between the register-file read stage and the writeback/memory stage.

## Interface
- WIDTH, 16, operand/result width (≥4)
- IMM_W, 7, immediate width of Ld_Sh
- SH_W, $clog2(WIDTH), derived; shift-amount bits taken from Ld_Sh[SH_W-1:0]
- Clk  in  1  single clock, rising edge
- Rst  in  1  synchronous, active-high reset
- In_Valid  in  1  instruction present
- In_Ready  out  1  instruction accepted when In_Valid&In_Ready
- Cond  in  2  00 always, 01 EQ (Z), 10 NE (!Z), 11 LT (N^V)
- Op_C  in  4  opcode
- Reg1, Reg2  in  WIDTH  operands
- Ld_Sh  in  IMM_W  immediate / shift amount
- Out_Valid  out  1  result held
- Out_Ready  in  1  consumer takes result
- Out  out  WIDTH  result / address
- Wr_En  out  1  writeback Out to destination register
- Mem_Op  out  2  00 none, 01 load address, 10 store address
- Flag  out  4  {N,Z,C,V} registered

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 OR, 0100 AND, 0101 XOR, 0110 MOVN (Out=zext(Ld_Sh), truncated to WIDTH if IMM_W>WIDTH), 0111 MOV (Out=Reg2), 1000 SHR logical, 1001 SHL, 1010 ROR (Reg1 by Ld_Sh[SH_W-1:0]), 1011 CMP, 1100 ADR (Out=Reg1+zext(Ld_Sh), mod 2^WIDTH), 1101 LDR (Out=Reg1, Mem_Op=01), 1110 STR (Out=Reg1, Mem_Op=10), 1111 NOP.
- Wr_En=1 for ADD SUB MUL OR AND XOR MOVN MOV SHR SHL ROR ADR; 0 for CMP LDR STR NOP.
- Flags updated only by ADD, SUB, MUL, CMP; all other ops leave them unchanged.
  - ADD: C=carry-out, V=signed overflow.
  - SUB/CMP: Reg1−Reg2; C=1 when no borrow (Reg1≥Reg2 unsigned), V=signed overflow.
  - MUL: Out=low WIDTH bits of product; C=V=(high half ≠0).
  - N=Out[WIDTH-1], Z=(Out==0); CMP computes both from the difference.
- Condition is evaluated at acceptance against Flag as it stands then, which already includes the previous instruction's update. If the condition fails: one-cycle response, Out_Valid=1, Out=0, Wr_En=0, Mem_Op=00, flags unchanged, MUL not started.
- FSM states:
  - IDLE → RESP on accepting a single-cycle op or a skipped op.
  - IDLE → MUL on accepting an executing MUL.
  - MUL → RESP after WIDTH iterations.
  - RESP → IDLE on Out_Ready with no new accept; RESP → RESP/MUL on Out_Ready with a simultaneous accept.
- In_Ready = (IDLE) | (RESP & Out_Ready). Low throughout MUL.
- Flags commit on the same edge that loads Out.

## Timing
- Single-cycle ops: Out_Valid rises on the edge after accept. Throughput is 1/cycle while Out_Ready=1.
- MUL: Out_Valid rises WIDTH+1 edges after accept (17 for WIDTH=16).
- Out, Wr_En and Mem_Op are stable while Out_Valid & !Out_Ready.
- Reset values: Out_Valid=0, Out=0, Wr_En=0, Mem_Op=00, Flag=0000, state IDLE, In_Ready=1 from the first cycle after reset.
- Rst mid-MUL or mid-RESP aborts immediately: the pending result is discarded and flags are cleared.
- Shift amount 0 returns Reg1 unchanged. Amounts use only the low SH_W bits of Ld_Sh.

## Configuration
- ALU_SEQ_MUL_EN defined: iterative multiplier compiled in, MUL behaves as above.
- ALU_SEQ_MUL_EN undefined: no multiplier logic and the MUL state does not exist. Opcode 0010 completes in one cycle as NOP: Out=0, Wr_En=0, flags unchanged.

## Structure
- alu_seq_pkg: opcode constants, condition codes, Mem_Op codes, flag bit indices (N=3, Z=2, C=1, V=0), FSM state enum.
- Sub-module alu_seq_mul: start/done shift-add multiplier, WIDTH-parametrised. Returns the low half plus a high-half-nonzero bit. Instantiated only under ALU_SEQ_MUL_EN.

## Test plan
- ADD 0x7FFF+0x0001, Cond 00 → next cycle Out=0x8000, Wr_En=1, Flag=1001 (N,V).
- CMP 5,5 then MOV Reg2=0x1234 Cond EQ → Out=0x1234, Wr_En=1. Same MOV with Cond NE → Out_Valid=1, Out=0, Wr_En=0, Flag stays 0110.
- MUL 0x0100×0x0100 → Out=0x0000, Flag=0111, Out_Valid exactly 17 cycles after accept, In_Ready=0 throughout. Without the macro → 1-cycle response, Wr_En=0.
- Out_Ready held low 3 cycles after ADD → Out stable, In_Ready=0. Release with In_Valid high → next instruction accepted that same cycle.
- ROR 0x0001 by 1 → 0x8000. SHL 0x0003 by 15 → 0x8000. SHR with Ld_Sh=0x10 → shift 0, Out=Reg1. LDR Reg1=0x00A0 → Out=0x00A0, Mem_Op=01, Wr_En=0.
- Rst asserted on MUL iteration 5 → next cycle Out_Valid=0, In_Ready=1, Flag=0000.
